// File: rtl/ppi_bus_master_if.sv
// ppi_bus_master_if: command/response handshake and 8255A bus signals of ppi_bus_master.
// The master modport is the bus-master view; the slave modport is the CPU/PPI environment view.
interface ppi_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_port;
  logic [7:0] cmd_data;
  logic       resp_valid;
  logic       resp_err;
  logic [7:0] resp_rdata;
  logic       ppi_cs_n;
  logic       ppi_wr_n;
  logic       ppi_rd_n;
  logic [1:0] ppi_a;
  logic [7:0] ppi_dout;
  logic       ppi_doe;
  logic [7:0] ppi_din;
  logic [7:0] mode_shadow;

  modport master (
    input  cmd_valid, cmd_op, cmd_port, cmd_data, ppi_din,
    output cmd_ready, resp_valid, resp_err, resp_rdata,
    output ppi_cs_n, ppi_wr_n, ppi_rd_n, ppi_a, ppi_dout, ppi_doe, mode_shadow
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_port, cmd_data, ppi_din,
    input  cmd_ready, resp_valid, resp_err, resp_rdata,
    input  ppi_cs_n, ppi_wr_n, ppi_rd_n, ppi_a, ppi_dout, ppi_doe, mode_shadow
  );
endinterface

// File: rtl/ppi_bus_master.sv
// ppi_bus_master: turns mode-set/BSR/port-write/port-read commands into timed 8255A bus cycles.
// A shadow of the last mode word lets it refuse writes to ports currently configured as inputs.
module ppi_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  ppi_bus_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_e;
  typedef enum logic [1:0] {OP_MODE, OP_BSR, OP_WRITE, OP_READ} op_e;

  localparam logic [3:0] SetupLd  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] StrobeLd = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HoldLd   = 4'(HOLD_CYC - 1);

  state_e     state_q;
  op_e        op_q;
  logic [3:0] cnt_q;
  logic       ready_q;
  logic       cs_n_q;
  logic       wr_n_q;
  logic       rd_n_q;
  logic [1:0] a_q;
  logic [7:0] dout_q;
  logic       doe_q;
  logic [7:0] rdata_q;
  logic       resp_valid_q;
  logic       resp_err_q;
  logic [7:0] resp_rdata_q;
  logic [7:0] mode_q;

  op_e        op_d;
  logic [1:0] a_d;
  logic [7:0] word_d;
  logic       err_d;

  // Accept-time decode: bus word, address and direction check against the current mode shadow.
  always_comb begin
    op_d   = op_e'(bus.cmd_op);
    a_d    = bus.cmd_op[1] ? bus.cmd_port : 2'b11;
    word_d = bus.cmd_data;
    err_d  = 1'b0;
    case (op_d)
      OP_MODE: word_d = {1'b1, (bus.cmd_data[6:5] == 2'b11) ? 2'b10 : bus.cmd_data[6:5],
                         bus.cmd_data[4:0]};
      OP_BSR:  word_d = {4'b0000, bus.cmd_data[3:0]};
      OP_WRITE: err_d = (bus.cmd_port == 2'b11) ||
                        ((bus.cmd_port == 2'b00) && mode_q[4]) ||
                        ((bus.cmd_port == 2'b01) && mode_q[1]) ||
                        ((bus.cmd_port == 2'b10) && mode_q[3] && mode_q[0]);
      OP_READ: begin
        word_d = 8'h00;
        err_d  = (bus.cmd_port == 2'b11);
      end
      default: word_d = bus.cmd_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_MODE;
      cnt_q        <= 4'd0;
      ready_q      <= 1'b1;
      cs_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      a_q          <= 2'b00;
      dout_q       <= 8'h00;
      doe_q        <= 1'b0;
      rdata_q      <= 8'h00;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 8'h00;
      mode_q       <= 8'h9B;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && ready_q) begin
            ready_q <= 1'b0;
            op_q    <= op_d;
            if (err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q <= SETUP;
              cnt_q   <= SetupLd;
              cs_n_q  <= 1'b0;
              a_q     <= a_d;
              dout_q  <= word_d;
              doe_q   <= (op_d != OP_READ);
            end
          end
        end
        SETUP: begin
          if (cnt_q == 4'd0) begin
            state_q <= STROBE;
            cnt_q   <= StrobeLd;
            if (op_q == OP_READ) rd_n_q <= 1'b0;
            else                 wr_n_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q <= HOLD;
            cnt_q   <= HoldLd;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            if (op_q == OP_READ) rdata_q <= bus.ppi_din;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (cnt_q == 4'd0) begin
            state_q      <= RESP;
            cs_n_q       <= 1'b1;
            doe_q        <= 1'b0;
            a_q          <= 2'b00;
            dout_q       <= 8'h00;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= (op_q == OP_READ) ? rdata_q : 8'h00;
            if (op_q == OP_MODE) mode_q <= dout_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 8'h00;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is gated by reset so it reads low for as long as reset is held.
  assign bus.cmd_ready   = ready_q & ~reset;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.ppi_cs_n    = cs_n_q;
  assign bus.ppi_wr_n    = wr_n_q;
  assign bus.ppi_rd_n    = rd_n_q;
  assign bus.ppi_a       = a_q;
  assign bus.ppi_dout    = dout_q;
  assign bus.ppi_doe     = doe_q;
  assign bus.mode_shadow = mode_q;

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb_ppi_bus_master: directed, self-checking bench for ppi_bus_master with default timing (1/3/1).
// Each command is issued, its bus cycle is watched cycle by cycle, then compared to hand-computed values.
module tb_ppi_bus_master;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int         obsLat;
  int         obsWrLow;
  int         obsRdLow;
  int         obsCsLow;
  int         obsDoeHigh;
  logic [7:0] obsWord;
  logic [1:0] obsAddr;
  logic       obsErr;
  logic [7:0] obsRdata;

  ppi_bus_master_if bus ();

  ppi_bus_master #(
    .SETUP_CYC (1),
    .STROBE_CYC(3),
    .HOLD_CYC  (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for ready, presents one command for a single accepting edge, then drops valid.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] port,
                               input logic [7:0] data);
    int waitCyc = 0;
    while (bus.cmd_ready !== 1'b1 && waitCyc < 20) begin
      tick();
      waitCyc++;
    end
    checkOutput("ready_before_issue", 32'(bus.cmd_ready), 1);
    bus.cmd_op    = op;
    bus.cmd_port  = port;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Watches the bus from the first cycle after accept until the response; PPI data only on the last strobe.
  task automatic observe(input logic [7:0] readVal);
    obsLat     = -1;
    obsWrLow   = 0;
    obsRdLow   = 0;
    obsCsLow   = 0;
    obsDoeHigh = 0;
    obsWord    = 8'hxx;
    obsAddr    = 2'bxx;
    obsErr     = 1'bx;
    obsRdata   = 8'hxx;
    for (int i = 1; i <= 20; i++) begin
      if (bus.ppi_cs_n === 1'b0) obsCsLow++;
      if (bus.ppi_doe === 1'b1) obsDoeHigh++;
      if (bus.ppi_wr_n === 1'b0) begin
        obsWrLow++;
        obsWord = bus.ppi_dout;
        obsAddr = bus.ppi_a;
      end
      if (bus.ppi_rd_n === 1'b0) begin
        obsRdLow++;
        obsAddr = bus.ppi_a;
      end
      bus.ppi_din = (bus.ppi_rd_n === 1'b0 && obsRdLow == 3) ? readVal : 8'hEE;
      if (bus.resp_valid === 1'b1) begin
        obsLat   = i;
        obsErr   = bus.resp_err;
        obsRdata = bus.resp_rdata;
        tick();
        break;
      end
      tick();
    end
    bus.ppi_din = 8'hEE;
  endtask

  task automatic runCmd(input string tag, input logic [1:0] op, input logic [1:0] port,
                        input logic [7:0] data, input logic [7:0] readVal,
                        input int expLat, input logic expErr);
    applyStimulus(op, port, data);
    observe(readVal);
    checkOutput({tag, "_latency"}, 32'(obsLat), 32'(expLat));
    checkOutput({tag, "_err"}, 32'(obsErr), 32'(expErr));
    checkOutput({tag, "_resp_one_cycle"}, 32'(bus.resp_valid), 0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_port  = 2'b00;
    bus.cmd_data  = 8'h00;
    bus.ppi_din   = 8'hEE;
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    checkOutput("rst_cs_n", 32'(bus.ppi_cs_n), 1);
    checkOutput("rst_wr_n", 32'(bus.ppi_wr_n), 1);
    checkOutput("rst_rd_n", 32'(bus.ppi_rd_n), 1);
    checkOutput("rst_a", 32'(bus.ppi_a), 0);
    checkOutput("rst_dout", 32'(bus.ppi_dout), 0);
    checkOutput("rst_doe", 32'(bus.ppi_doe), 0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 0);
    checkOutput("rst_resp_err", 32'(bus.resp_err), 0);
    checkOutput("rst_resp_rdata", 32'(bus.resp_rdata), 0);
    checkOutput("rst_mode_shadow", 32'(bus.mode_shadow), 32'h9B);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);

    $display("[TB] write port A while all ports are inputs");
    runCmd("wrA_input", 2'b10, 2'b00, 8'hA5, 8'h00, 1, 1'b1);
    checkOutput("wrA_input_cs_never_low", 32'(obsCsLow), 0);
    checkOutput("wrA_input_mode", 32'(bus.mode_shadow), 32'h9B);

    $display("[TB] BSR set bit 7");
    runCmd("bsr", 2'b01, 2'b00, 8'h0F, 8'h00, 6, 1'b0);
    checkOutput("bsr_word", 32'(obsWord), 32'h0F);
    checkOutput("bsr_addr", 32'(obsAddr), 3);
    checkOutput("bsr_mode_unchanged", 32'(bus.mode_shadow), 32'h9B);

    $display("[TB] mode-set all outputs");
    runCmd("mode80", 2'b00, 2'b00, 8'h00, 8'h00, 6, 1'b0);
    checkOutput("mode80_word", 32'(obsWord), 32'h80);
    checkOutput("mode80_addr", 32'(obsAddr), 3);
    checkOutput("mode80_wr_low", 32'(obsWrLow), 3);
    checkOutput("mode80_cs_low", 32'(obsCsLow), 5);
    checkOutput("mode80_doe_high", 32'(obsDoeHigh), 5);
    checkOutput("mode80_shadow", 32'(bus.mode_shadow), 32'h80);

    $display("[TB] write port A with ports as outputs");
    runCmd("wrA", 2'b10, 2'b00, 8'hA5, 8'h00, 6, 1'b0);
    checkOutput("wrA_word", 32'(obsWord), 32'hA5);
    checkOutput("wrA_addr", 32'(obsAddr), 0);
    checkOutput("wrA_rd_low", 32'(obsRdLow), 0);

    $display("[TB] read port B");
    runCmd("rdB", 2'b11, 2'b01, 8'h00, 8'h3C, 6, 1'b0);
    checkOutput("rdB_rd_low", 32'(obsRdLow), 3);
    checkOutput("rdB_wr_low", 32'(obsWrLow), 0);
    checkOutput("rdB_doe_high", 32'(obsDoeHigh), 0);
    checkOutput("rdB_addr", 32'(obsAddr), 1);
    checkOutput("rdB_rdata", 32'(obsRdata), 32'h3C);
    checkOutput("rdB_rdata_cleared", 32'(bus.resp_rdata), 0);

    $display("[TB] mode-set with group A mode 11 normalised");
    runCmd("mode60", 2'b00, 2'b00, 8'h60, 8'h00, 6, 1'b0);
    checkOutput("mode60_word", 32'(obsWord), 32'hC0);
    checkOutput("mode60_shadow", 32'(bus.mode_shadow), 32'hC0);

    $display("[TB] illegal port on a port op");
    runCmd("rd_port3", 2'b11, 2'b11, 8'h00, 8'h00, 1, 1'b1);
    checkOutput("rd_port3_cs_never_low", 32'(obsCsLow), 0);
    checkOutput("rd_port3_rdata", 32'(obsRdata), 0);

    $display("[TB] port B input, port C outputs");
    runCmd("mode02", 2'b00, 2'b00, 8'h02, 8'h00, 6, 1'b0);
    checkOutput("mode02_shadow", 32'(bus.mode_shadow), 32'h82);
    runCmd("wrB_input", 2'b10, 2'b01, 8'h55, 8'h00, 1, 1'b1);
    runCmd("wrC", 2'b10, 2'b10, 8'h33, 8'h00, 6, 1'b0);
    checkOutput("wrC_word", 32'(obsWord), 32'h33);
    checkOutput("wrC_addr", 32'(obsAddr), 2);

    $display("[TB] both halves of port C input");
    runCmd("mode09", 2'b00, 2'b00, 8'h09, 8'h00, 6, 1'b0);
    checkOutput("mode09_shadow", 32'(bus.mode_shadow), 32'h89);
    runCmd("wrC_input", 2'b10, 2'b10, 8'h33, 8'h00, 1, 1'b1);

    $display("[TB] reset during write strobe");
    applyStimulus(2'b10, 2'b00, 8'h5A);
    tick();
    checkOutput("abort_in_strobe", 32'(bus.ppi_wr_n), 0);
    reset = 1'b1;
    tick();
    checkOutput("abort_wr_n", 32'(bus.ppi_wr_n), 1);
    checkOutput("abort_cs_n", 32'(bus.ppi_cs_n), 1);
    checkOutput("abort_doe", 32'(bus.ppi_doe), 0);
    checkOutput("abort_resp_valid", 32'(bus.resp_valid), 0);
    reset = 1'b0;
    #1;
    checkOutput("abort_cmd_ready", 32'(bus.cmd_ready), 1);
    checkOutput("abort_mode_shadow", 32'(bus.mode_shadow), 32'h9B);
    begin
      int respSeen = 0;
      for (int i = 0; i < 8; i++) begin
        if (bus.resp_valid === 1'b1) respSeen++;
        tick();
      end
      checkOutput("abort_no_resp", 32'(respSeen), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
